// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between the multicycle RISC-V datapath and data memory.
// Accepts one request at a time, validates the encoding and alignment, drives a
// word-addressed memory port with byte strobes, and waits for mem_ack with a
// timeout. It then returns a single-cycle response with extended load data.
module rv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Last counter value still allowed in WAIT before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Funct3 must match the direction, and the address must suit the access size.
  function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok_s;
    case (f3)
      3'b000:  ok_s = 1'b1;
      3'b001:  ok_s = ~a[0];
      3'b010:  ok_s = (a == 2'b00);
      3'b100:  ok_s = ~we;
      3'b101:  ok_s = ~we & ~a[0];
      default: ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

  // Byte-lane strobes for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] strb_s;
    case (f3[1:0])
      2'b00:   strb_s = 4'b0001 << a;
      2'b01:   strb_s = a[1] ? 4'b1100 : 4'b0011;
      default: strb_s = 4'b1111;
    endcase
    return strb_s;
  endfunction

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] data_s;
    case (f3[1:0])
      2'b00:   data_s = {4{d[7:0]}};
      2'b01:   data_s = {2{d[15:0]}};
      default: data_s = d;
    endcase
    return data_s;
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    byte_s = d[{a, 3'b000} +: 8];
    half_s = d[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  res_s = {24'h000000, byte_s};
      3'b001:  res_s = {{16{half_s[15]}}, half_s};
      3'b101:  res_s = {16'h0000, half_s};
      default: res_s = d;
    endcase
    return res_s;
  endfunction

  state_t      state_r, next_state_s;
  logic [7:0]  cnt_r, nxt_cnt_s;
  logic        we_r, nxt_we_s;
  logic [2:0]  funct3_r, nxt_funct3_s;
  logic [1:0]  addr_lo_r, nxt_addr_lo_s;
  logic        mem_req_r, nxt_mem_req_s;
  logic        mem_we_r, nxt_mem_we_s;
  logic [31:0] mem_addr_r, nxt_mem_addr_s;
  logic [3:0]  mem_wstrb_r, nxt_mem_wstrb_s;
  logic [31:0] mem_wdata_r, nxt_mem_wdata_s;
  logic        rsp_valid_r, nxt_rsp_valid_s;
  logic        rsp_err_r, nxt_rsp_err_s;
  logic [31:0] rsp_rdata_r, nxt_rsp_rdata_s;
  logic        accept_s;
  logic        legal_s;
  logic        timeout_s;

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid & req_ready;
  assign legal_s   = req_legal(req_we, req_funct3, req_addr[1:0]);
  assign timeout_s = (cnt_r == TO_LAST);

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_wdata = mem_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection: legal requests wait on memory, illegal go straight to RESP.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = legal_s ? ST_WAIT : ST_RESP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack || timeout_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered memory-port, response and bookkeeping outputs.
  always_comb begin
    nxt_cnt_s       = cnt_r;
    nxt_we_s        = we_r;
    nxt_funct3_s    = funct3_r;
    nxt_addr_lo_s   = addr_lo_r;
    nxt_mem_req_s   = mem_req_r;
    nxt_mem_we_s    = mem_we_r;
    nxt_mem_addr_s  = mem_addr_r;
    nxt_mem_wstrb_s = mem_wstrb_r;
    nxt_mem_wdata_s = mem_wdata_r;
    nxt_rsp_valid_s = 1'b0;
    nxt_rsp_err_s   = 1'b0;
    nxt_rsp_rdata_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          nxt_we_s      = req_we;
          nxt_funct3_s  = req_funct3;
          nxt_addr_lo_s = req_addr[1:0];
          nxt_cnt_s     = 8'd0;
          if (legal_s) begin
            nxt_mem_req_s   = 1'b1;
            nxt_mem_we_s    = req_we;
            nxt_mem_addr_s  = {req_addr[31:2], 2'b00};
            nxt_mem_wstrb_s = req_we ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
            nxt_mem_wdata_s = req_we ? store_data(req_funct3, req_wdata) : 32'h0000_0000;
          end else begin
            nxt_rsp_valid_s = 1'b1;
            nxt_rsp_err_s   = 1'b1;
          end
        end else begin
          nxt_mem_req_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          nxt_mem_req_s   = 1'b0;
          nxt_rsp_valid_s = 1'b1;
          nxt_rsp_rdata_s = we_r ? 32'h0000_0000 : load_ext(funct3_r, addr_lo_r, mem_rdata);
        end else if (timeout_s) begin
          nxt_mem_req_s   = 1'b0;
          nxt_rsp_valid_s = 1'b1;
          nxt_rsp_err_s   = 1'b1;
        end else begin
          nxt_cnt_s = cnt_r + 8'd1;
        end
      end
      ST_RESP: nxt_mem_req_s = 1'b0;
      default: nxt_mem_req_s = 1'b0;
    endcase
  end

  // Output and request-context registers; reset clears any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= 8'd0;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      cnt_r       <= nxt_cnt_s;
      we_r        <= nxt_we_s;
      funct3_r    <= nxt_funct3_s;
      addr_lo_r   <= nxt_addr_lo_s;
      mem_req_r   <= nxt_mem_req_s;
      mem_we_r    <= nxt_mem_we_s;
      mem_addr_r  <= nxt_mem_addr_s;
      mem_wstrb_r <= nxt_mem_wstrb_s;
      mem_wdata_r <= nxt_mem_wdata_s;
      rsp_valid_r <= nxt_rsp_valid_s;
      rsp_err_r   <= nxt_rsp_err_s;
      rsp_rdata_r <= nxt_rsp_rdata_s;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed bench for rv_lsu with TIMEOUT_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rv_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_pass;
  int n_total;

  rv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the acceptance edge); returns in cycle 1.
  task automatic start_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
    req_wdata  = 32'h5555_5555;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_total++; if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== 70'd0)
      $display("FAIL reset_mem got %h required 0", {mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata}); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0)
      $display("FAIL reset_rsp got %h required 0", {rsp_valid, rsp_err, rsp_rdata}); else n_pass++;
    n_total++; if (req_ready !== 1'b1)
      $display("FAIL reset_ready got %b required 1", req_ready); else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_lw();
    start_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    n_total++; if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h0000_0100, 4'b0000})
      $display("FAIL lw_mem got req=%b we=%b addr=%h strb=%b required 1 0 00000100 0000", mem_req, mem_we, mem_addr, mem_wstrb); else n_pass++;
    n_total++; if ({req_ready, rsp_valid} !== 2'b00)
      $display("FAIL lw_c1_busy got ready=%b rsp=%b required 0 0", req_ready, rsp_valid); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata, mem_req} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0})
      $display("FAIL lw_rsp got v=%b e=%b d=%h mreq=%b required 1 0 deadbeef 0", rsp_valid, rsp_err, rsp_rdata, mem_req); else n_pass++;
    step();
    n_total++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL lw_c3 got rsp=%b ready=%b required 0 1", rsp_valid, req_ready); else n_pass++;
  endtask

  // Byte/halfword loads, each issued in the cycle right after the previous RESP.
  task automatic test_loads();
    logic [2:0]  f3_tab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad_tab [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] md_tab [4] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] ex_tab [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      start_req(1'b0, f3_tab[i], ad_tab[i], 32'h0);
      n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100})
        $display("FAIL load%0d_mem got req=%b addr=%h required 1 00000100", i, mem_req, mem_addr); else n_pass++;
      mem_ack = 1'b1; mem_rdata = md_tab[i];
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, ex_tab[i]})
        $display("FAIL load%0d_rsp got v=%b e=%b d=%h required 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, ex_tab[i]); else n_pass++;
      step();
    end
  endtask

  task automatic test_stores();
    start_req(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
    n_total++; if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD})
      $display("FAIL sh_mem got req=%b we=%b addr=%h strb=%b wd=%h required 1 1 00000020 1100 abcdabcd", mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata); else n_pass++;
    req_addr = 32'hFFFF_FFFF; req_funct3 = 3'b010;
    step();
    n_total++; if ({mem_req, mem_addr, mem_wstrb, mem_wdata, rsp_valid} !== {1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD, 1'b0})
      $display("FAIL sh_hold got req=%b addr=%h strb=%b wd=%h rsp=%b required held, rsp 0", mem_req, mem_addr, mem_wstrb, mem_wdata, rsp_valid); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL sh_rsp got v=%b e=%b d=%h required 1 0 00000000", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    step();
    start_req(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5);
    n_total++; if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b0010, 32'hA5A5_A5A5, 32'h0})
      $display("FAIL sb_mem got strb=%b wd=%h addr=%h required 0010 a5a5a5a5 00000000", mem_wstrb, mem_wdata, mem_addr); else n_pass++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    start_req(1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D);
    n_total++; if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b1111, 32'hCAFE_F00D, 32'h8})
      $display("FAIL sw_mem got strb=%b wd=%h addr=%h required 1111 cafef00d 00000008", mem_wstrb, mem_wdata, mem_addr); else n_pass++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  // Misaligned or badly encoded requests answer in cycle 1 without touching memory.
  task automatic test_illegal();
    logic        we_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_tab [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    logic [31:0] ad_tab [4] = '{32'h102, 32'h0, 32'h101, 32'h201};
    for (int i = 0; i < 4; i++) begin
      start_req(we_tab[i], f3_tab[i], ad_tab[i], 32'hFFFF_FFFF);
      n_total++; if ({rsp_valid, rsp_err, rsp_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0})
        $display("FAIL illegal%0d_c1 got v=%b e=%b d=%h mreq=%b required 1 1 00000000 0", i, rsp_valid, rsp_err, rsp_rdata, mem_req); else n_pass++;
      step();
      n_total++; if ({rsp_valid, mem_req, req_ready} !== 3'b001)
        $display("FAIL illegal%0d_c2 got v=%b mreq=%b ready=%b required 0 0 1", i, rsp_valid, mem_req, req_ready); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    start_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      n_total++; if ({mem_req, rsp_valid} !== 2'b10)
        $display("FAIL to_wait_c%0d got mreq=%b rsp=%b required 1 0", c, mem_req, rsp_valid); else n_pass++;
      step();
    end
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0})
      $display("FAIL to_rsp got v=%b e=%b d=%h mreq=%b required 1 1 00000000 0", rsp_valid, rsp_err, rsp_rdata, mem_req); else n_pass++;
    step();
    start_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    step(); step(); step();
    n_total++; if (mem_req !== 1'b1)
      $display("FAIL to_ack_c4 got mreq=%b required 1", mem_req); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1122_3344})
      $display("FAIL to_ack_rsp got v=%b e=%b d=%h required 1 0 11223344", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    start_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    step();
    #3 reset = 1'b1;
    #1;
    n_total++; if ({mem_req, rsp_valid, req_ready} !== 3'b001)
      $display("FAIL rst_mid_async got mreq=%b rsp=%b ready=%b required 0 0 1", mem_req, rsp_valid, req_ready); else n_pass++;
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid === 1'b1 || mem_req === 1'b1) seen++;
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_total++; if (seen !== 0)
      $display("FAIL rst_mid_quiet got %0d active cycles required 0", seen); else n_pass++;
    start_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h300})
      $display("FAIL rst_after_mem got req=%b addr=%h required 1 00000300", mem_req, mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0BAD_CAFE})
      $display("FAIL rst_after_rsp got v=%b e=%b d=%h required 1 0 0badcafe", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    step();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
